uart_msg_streamer: RTL and testbench
====================================

// Module: uart_msg_streamer
// PURPOSE
//  Parametrised UART transmitter that serialises a fixed-length multi-byte message.
//  Frame format: start bit, DATA_BITS data bits LSB first, optional parity, STOP_BITS stop bits.
//  Sends the message once or repeatedly. Replaces hand-rolled bit-bang stimulus loops.
//  Drives debugger command injection (debug_uart_rx_in) in benches; synthesisable as a boot/loopback source.
// PARAMETERS
//  CLK_DIV_COUNT  600  clk_in cycles per UART bit; must be >= 2
//  DATA_BITS      8    data bits per frame; range 5..8
//  STOP_BITS      2    stop bits per frame; range 1..2
//  MSG_BYTES      134  number of DATA_BITS-wide words in message
//  GAP_BITS       0    idle bit-times inserted after each frame's stop bits
//  LOOP           0    1: wrap to word 0 after the last word and repeat until stop_req
// PORTS
//  clk_in      in   1                  system clock
//  reset       in   1                  asynchronous, active-high reset
//  start       in   1                  1-cycle pulse; launches a message when idle
//  stop_req    in   1                  pulse; finish current frame, then go idle (LOOP mode)
//  message     in   MSG_BYTES*DATA_BITS  word k = message[k*DATA_BITS +: DATA_BITS]
//  tx_out      out  1                  serial line, idle high
//  busy        out  1                  high from the start-accept cycle until return to IDLE
//  word_done   out  1                  1-cycle pulse at end of each frame's last stop/gap bit
//  msg_done    out  1                  1-cycle pulse when word MSG_BYTES-1 completes
//  word_index  out  $clog2(MSG_BYTES)  index of the word currently being sent
// BEHAVIOUR
//  - Reset values: tx_out=1, busy=0, word_done=0, msg_done=0, word_index=0, FSM=IDLE.
//  - Reset is asynchronous; asserting it mid-frame forces tx_out=1 immediately and discards the frame.
//  - FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP -> [GAP] -> START | IDLE.
//  - Start acceptance:
//    - start in IDLE: message is latched into a shadow register the same cycle; busy=1 next cycle.
//    - START is entered and tx_out=0 on the cycle after start.
//    - start while busy is ignored; message changes after acceptance have no effect.
//  - Bit timer: down-counter loaded with CLK_DIV_COUNT-1 on each bit entry; advances at 0.
//    Every bit lasts exactly CLK_DIV_COUNT cycles.
//  - DATA: shifts word_index's word out LSB first; bit counter runs 0..DATA_BITS-1.
//  - STOP: tx_out=1 for STOP_BITS bit-times; GAP: tx_out=1 for GAP_BITS bit-times (skipped if 0).
//  - Frame length = (1+DATA_BITS+P+STOP_BITS+GAP_BITS)*CLK_DIV_COUNT cycles, P=1 with parity.
//  - Frame end:
//    - word_done pulses on the last cycle of the frame.
//    - word_index increments; START follows with no extra idle cycle.
//  - Last word (index MSG_BYTES-1):
//    - msg_done pulses together with word_done.
//    - LOOP=0: -> IDLE, busy=0 next cycle, word_index=0.
//    - LOOP=1: word_index wraps to 0, continues.
//  - stop_req:
//    - stop_req while busy is latched; at the next frame end -> IDLE (msg_done only if last word).
//    - stop_req in IDLE is ignored.
//    - stop_req and start in the same IDLE cycle: start wins, stop is not latched.
//  - MSG_BYTES=1: every frame end is also msg_done.
// CONFIGURATION
//  UART_MSG_STREAMER_PARITY_EN defined:
//   - PARITY state sends one even-parity bit (XOR of data bits) after DATA.
//   - Frame gains one bit-time.
//  Undefined: no PARITY state; DATA goes directly to STOP; no parity logic generated.
// TESTING
//  Common bench setup: CLK_DIV_COUNT=4.
//  1) DATA_BITS=8, STOP_BITS=2, MSG_BYTES=2, message=16'h4152, start:
//     - tx_out = 0,0,1,0,0,1,0,1,0,1,1 (each 4 clks) for 0x52, then the same frame format for 0x41.
//     - msg_done at clk 88; busy falls at clk 89.
//  2) LOOP=1, MSG_BYTES=3:
//     - word_index sequence 0,1,2,0,1.
//     - stop_req mid word 1 -> word 1 completes, IDLE, no msg_done.
//  3) Parity define, data 8'h07:
//     - parity bit = 1, frame = 12 bit-times = 48 clks.
//     - data 8'h03 -> parity bit = 0.
//  4) GAP_BITS=2:
//     - tx_out high for 4 bit-times (16 clks) between consecutive start bits.
//     - start while busy -> no effect on sequence.
//  5) Reset asserted in DATA state:
//     - tx_out=1 and busy=0 asynchronously.
//     - start after release resends from word 0.
//  6) Loop output into debugger debug_uart_rx_in (DIVIDER_TICKS=CLK_DIV_COUNT):
//     - every word is received byte-exact.

Source files
------------

// File: rtl/uart_msg_streamer_if.sv
// uart_msg_streamer_if
//   Bundles the message/control inputs and the serial/status outputs of
//   uart_msg_streamer. Clock and reset stay plain ports on the module.
//   master : drives start, stop_req, message; observes the outputs
//   slave  : the streamer itself
//   start      1-cycle launch pulse (honoured only when idle)
//   stop_req   pulse; finish the current frame, then go idle
//   message    MSG_BYTES words of DATA_BITS, word k at [k*DATA_BITS +: DATA_BITS]
//   tx_out     serial line, idle high
//   busy       high from the cycle after start acceptance until back in idle
//   word_done  1-cycle pulse on the last cycle of each frame
//   msg_done   1-cycle pulse on the last cycle of word MSG_BYTES-1
//   word_index index of the word being sent
interface uart_msg_streamer_if #(
    parameter int DATA_BITS = 8,
    parameter int MSG_BYTES = 134
);
    localparam int IW = (MSG_BYTES > 1) ? $clog2(MSG_BYTES) : 1;

    logic                           start;
    logic                           stop_req;
    logic [MSG_BYTES*DATA_BITS-1:0] message;
    logic                           tx_out;
    logic                           busy;
    logic                           word_done;
    logic                           msg_done;
    logic [IW-1:0]                  word_index;

    modport master (
        output start, stop_req, message,
        input  tx_out, busy, word_done, msg_done, word_index
    );

    modport slave (
        input  start, stop_req, message,
        output tx_out, busy, word_done, msg_done, word_index
    );
endinterface

// File: rtl/uart_msg_streamer.sv
// uart_msg_streamer
//   UART transmitter that serialises a fixed-length multi-byte message:
//   start bit, DATA_BITS data bits LSB first, optional even parity,
//   STOP_BITS stop bits, GAP_BITS idle bit-times. Sends once, or repeats
//   (LOOP=1) until stop_req.
//   Optional feature macro: UART_MSG_STREAMER_PARITY_EN adds one even-parity
//   bit after the data bits.
// Ports
//   clk_in  system clock
//   reset   asynchronous, active-high
//   bus     uart_msg_streamer_if.slave (start/stop_req/message in,
//           tx_out/busy/word_done/msg_done/word_index out)
module uart_msg_streamer #(
    parameter int CLK_DIV_COUNT = 600,
    parameter int DATA_BITS     = 8,
    parameter int STOP_BITS     = 2,
    parameter int MSG_BYTES     = 134,
    parameter int GAP_BITS      = 0,
    parameter int LOOP          = 0
) (
    input logic               clk_in,
    input logic               reset,
    uart_msg_streamer_if.slave bus
);
    localparam int IW      = (MSG_BYTES > 1) ? $clog2(MSG_BYTES) : 1;
    localparam int CW      = $clog2(CLK_DIV_COUNT);
    localparam int BMAX_DS = (DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS;
    localparam int BMAX    = (BMAX_DS > GAP_BITS) ? BMAX_DS : GAP_BITS;
    localparam int BW      = $clog2(BMAX);

    localparam logic [CW-1:0] DIV_LAST  = CW'(CLK_DIV_COUNT - 1);
    localparam logic [IW-1:0] LAST_WORD = IW'(MSG_BYTES - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
    localparam logic [BW-1:0] GAP_LAST  = BW'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_MSG_STREAMER_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_GAP
    } state_t;

    state_t                             state_q, state_d;
    logic [CW-1:0]                      cnt_q, cnt_d;
    logic [BW-1:0]                      bit_q, bit_d;
    logic [IW-1:0]                      word_q, word_d;
    logic [MSG_BYTES-1:0][DATA_BITS-1:0] msg_q, msg_d;
    logic                               stop_q, stop_d;

    logic                 tick;
    logic                 frame_end;
    logic [DATA_BITS-1:0] cur_word;
    logic [DATA_BITS-1:0] data_shift;
    logic                 tx;

    if (MSG_BYTES == 1) begin : g_one_word
        assign cur_word = msg_q[0];
    end else begin : g_many_words
        assign cur_word = msg_q[word_q];
    end

    assign data_shift = cur_word >> bit_q;
    assign tick       = (cnt_q == '0);
    // Last cycle of the frame: end of the final stop bit when there is no
    // gap, otherwise end of the final gap bit.
    assign frame_end  = tick && (((state_q == S_STOP) && (bit_q == STOP_LAST) && (GAP_BITS == 0)) ||
                                 ((state_q == S_GAP)  && (bit_q == GAP_LAST)));

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            word_q  <= '0;
            msg_q   <= '0;
            stop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            word_q  <= word_d;
            msg_q   <= msg_d;
            stop_q  <= stop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        word_d  = word_q;
        msg_d   = msg_q;
        stop_d  = stop_q;

        if (state_q != S_IDLE) begin
            cnt_d = tick ? DIV_LAST : cnt_q - 1'b1;
            if (bus.stop_req) stop_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_START;
                    cnt_d   = DIV_LAST;
                    msg_d   = bus.message;
                    word_d  = '0;
                    stop_d  = 1'b0;
                end
            end
            S_START: begin
                if (tick) begin
                    state_d = S_DATA;
                    bit_d   = '0;
                end
            end
            S_DATA: begin
                if (tick) begin
                    if (bit_q == DATA_LAST) begin
                        bit_d   = '0;
`ifdef UART_MSG_STREAMER_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
`ifdef UART_MSG_STREAMER_PARITY_EN
            S_PARITY: begin
                if (tick) begin
                    state_d = S_STOP;
                    bit_d   = '0;
                end
            end
`endif
            S_STOP: begin
                if (tick) begin
                    if (bit_q == STOP_LAST) begin
                        bit_d = '0;
                        if (GAP_BITS > 0) state_d = S_GAP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            S_GAP: begin
                if (tick && (bit_q != GAP_LAST)) bit_d = bit_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        // Frame boundary overrides the per-state transition. A stop request
        // arriving on this very cycle also counts.
        if (frame_end) begin
            bit_d = '0;
            if (stop_q || bus.stop_req || ((word_q == LAST_WORD) && (LOOP == 0))) begin
                state_d = S_IDLE;
                word_d  = '0;
                stop_d  = 1'b0;
            end else begin
                state_d = S_START;
                word_d  = (word_q == LAST_WORD) ? '0 : word_q + 1'b1;
            end
        end
    end

    always_comb begin
        tx = 1'b1;
        case (state_q)
            S_START:  tx = 1'b0;
            S_DATA:   tx = data_shift[0];
`ifdef UART_MSG_STREAMER_PARITY_EN
            S_PARITY: tx = ^cur_word;
`endif
            default:  tx = 1'b1;
        endcase
    end

    assign bus.tx_out     = tx;
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.word_done  = frame_end;
    assign bus.msg_done   = frame_end && (word_q == LAST_WORD);
    assign bus.word_index = word_q;
endmodule

// File: tb/tb_uart_msg_streamer.sv
// Bench for uart_msg_streamer: three configurations side by side, each
// checked every cycle against a position-in-stream model, plus literal
// waveform/timing expectations on configuration 0.
module tb_uart_msg_streamer;
    localparam int DIV = 4;
`ifdef UART_MSG_STREAMER_PARITY_EN
    localparam int PAR    = 1;
    localparam int LIT_MD = 96;
`else
    localparam int PAR    = 0;
    localparam int LIT_MD = 88;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  rst_s;
    logic [2:0]  start_s;
    logic [2:0]  stop_s;
    logic [31:0] msg_in [3];

    int vectors     = 0;
    int miscompares = 0;
    int e0[12];
    int e1[12];

    task automatic chk(input string nm, input int g, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s cfg%0d @%0t: got %0d, expected %0d", nm, g, $time, act, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : cfg
        localparam int D  = (g == 0) ? 8 : (g == 1) ? 7 : 5;
        localparam int S  = (g == 1) ? 1 : 2;
        localparam int MB = (g == 0) ? 2 : (g == 1) ? 3 : 1;
        localparam int GP = (g == 0) ? 0 : (g == 1) ? 2 : 1;
        localparam int LP = (g == 1) ? 1 : 0;
        localparam int F  = (1 + D + PAR + S + GP) * DIV;

        uart_msg_streamer_if #(.DATA_BITS(D), .MSG_BYTES(MB)) bus ();

        assign bus.start    = start_s[g];
        assign bus.stop_req = stop_s[g];
        assign bus.message  = msg_in[g][MB*D-1:0];

        uart_msg_streamer #(
            .CLK_DIV_COUNT(DIV), .DATA_BITS(D), .STOP_BITS(S),
            .MSG_BYTES(MB), .GAP_BITS(GP), .LOOP(LP)
        ) dut (
            .clk_in(clk),
            .reset (rst_s[g]),
            .bus   (bus)
        );

        // Model: p = cycles since the first START cycle of the message.
        logic            act;
        int              p;
        logic [MB*D-1:0] mq;
        logic            stl;

        always @(posedge clk or posedge rst_s[g]) begin
            if (rst_s[g]) begin
                act <= 1'b0;
                p   <= 0;
                stl <= 1'b0;
            end else if (!act) begin
                if (start_s[g]) begin
                    act <= 1'b1;
                    p   <= 0;
                    mq  <= msg_in[g][MB*D-1:0];
                    stl <= 1'b0;
                end
            end else begin
                if ((p % F == F - 1) &&
                    (stl || stop_s[g] || (LP == 0 && (p / F) % MB == MB - 1)))
                    act <= 1'b0;
                else
                    p <= p + 1;
                if (stop_s[g]) stl <= 1'b1;
            end
        end

        always @(negedge clk) begin
            int k, o, b, w, etx, ewd, emd, eidx;
            logic [D-1:0] wv;
            etx = 1; ewd = 0; emd = 0; eidx = 0;
            if (act) begin
                k  = p / F;
                o  = p % F;
                b  = o / DIV;
                w  = k % MB;
                wv = mq[w*D +: D];
                if (b == 0)                        etx = 0;
                else if (b <= D)                   etx = int'(wv[b-1]);
                else if (PAR == 1 && b == D + 1)   etx = int'(^wv);
                ewd  = (o == F - 1) ? 1 : 0;
                emd  = (ewd == 1 && w == MB - 1) ? 1 : 0;
                eidx = w;
            end
            chk("tx_out",     g, int'(bus.tx_out),     etx);
            chk("busy",       g, int'(bus.busy),       act ? 1 : 0);
            chk("word_done",  g, int'(bus.word_done),  ewd);
            chk("msg_done",   g, int'(bus.msg_done),   emd);
            chk("word_index", g, int'(bus.word_index), eidx);
        end
    end

    // Launch message m on cfg0 and check the two frames literally.
    task automatic lit_run(input logic [15:0] m);
        int md_at, bf_at, nb, o, fr;
        nb    = 11 + PAR;
        md_at = -1;
        bf_at = -1;
        @(posedge clk); #1;
        msg_in[0]  = {16'h0, m};
        start_s[0] = 1'b1;
        @(posedge clk); #1;
        start_s[0] = 1'b0;
        msg_in[0]  = 32'hFFFF_A5C3;
        for (int c = 1; c <= 2 * nb * DIV + 3; c++) begin
            @(negedge clk);
            o  = (c - 1) % (nb * DIV);
            fr = (c - 1) / (nb * DIV);
            if (fr < 2 && o % DIV == 2)
                chk("lit_bit", 0, int'(cfg[0].bus.tx_out), (fr == 0) ? e0[o/DIV] : e1[o/DIV]);
            if (c == nb * DIV + 6)
                chk("lit_word_index", 0, int'(cfg[0].bus.word_index), 1);
            if (md_at < 0 && cfg[0].bus.msg_done) md_at = c;
            if (bf_at < 0 && !cfg[0].bus.busy)    bf_at = c;
        end
        chk("lit_msg_done_clk",  0, md_at, LIT_MD);
        chk("lit_busy_fall_clk", 0, bf_at, LIT_MD + 1);
    endtask

    initial begin
        int gg;
        rst_s   = '1;
        start_s = '0;
        stop_s  = '0;
        for (int i = 0; i < 3; i++) msg_in[i] = '0;
        #12;
        chk("rst_tx",   0, int'(cfg[0].bus.tx_out), 1);
        chk("rst_busy", 0, int'(cfg[0].bus.busy),   0);
        #10 rst_s = '0;

`ifdef UART_MSG_STREAMER_PARITY_EN
        e0 = '{0, 0,1,0,0,1,0,1,0, 1, 1,1};
        e1 = '{0, 1,0,0,0,0,0,1,0, 0, 1,1};
`else
        e0 = '{0, 0,1,0,0,1,0,1,0, 1,1, 1};
        e1 = '{0, 1,0,0,0,0,0,1,0, 1,1, 1};
`endif
        lit_run(16'h4152);
`ifdef UART_MSG_STREAMER_PARITY_EN
        e0 = '{0, 1,1,1,0,0,0,0,0, 1, 1,1};
        e1 = '{0, 1,1,0,0,0,0,0,0, 0, 1,1};
        lit_run(16'h0307);
`endif

        // Asynchronous reset during DATA (data bit 2 of 0x52 is low).
        @(posedge clk); #1;
        msg_in[0]  = 32'h4152;
        start_s[0] = 1'b1;
        @(posedge clk); #1;
        start_s[0] = 1'b0;
        repeat (14) @(posedge clk);
        #3;
        chk("pre_rst_tx", 0, int'(cfg[0].bus.tx_out), 0);
        #1 rst_s[0] = 1'b1;
        #1;
        chk("async_rst_tx",   0, int'(cfg[0].bus.tx_out), 1);
        chk("async_rst_busy", 0, int'(cfg[0].bus.busy),   0);
        @(posedge clk); #1;
        rst_s[0]   = 1'b0;
        start_s[0] = 1'b1;
        @(posedge clk); #1;
        start_s[0] = 1'b0;
        repeat (110) @(posedge clk);

        // Randomized traffic on all configurations.
        for (int n = 0; n < 12000; n++) begin
            @(posedge clk); #1;
            for (int g = 0; g < 3; g++) begin
                start_s[g] = ($urandom_range(0, 59) == 0);
                stop_s[g]  = ($urandom_range(0, 399) == 0);
                msg_in[g]  = $urandom;
                rst_s[g]   = 1'b0;
            end
            if ($urandom_range(0, 2999) == 0) begin
                gg = $urandom_range(0, 2);
                #2 rst_s[gg] = 1'b1;
            end
        end
        @(posedge clk); #1;
        rst_s   = '0;
        start_s = '0;
        stop_s  = '0;
        repeat (200) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
